// File: rtl/pipe_column_gen_if.sv
// pipe_column_gen_if
// Column stream between the obstacle generator and the playfield shifter.
// The _i/_o suffixes are named from the generator's side.
//   step_i      - advance one column this cycle
//   col_o       - current column, bit 0 = top row, 1 = wall
//   colValid_o  - one-cycle pulse, new column on col_o
//   pipeStart_o - one-cycle pulse with the first wall column of an obstacle
//   gapTop_o    - top row index of the current obstacle's gap
//   gapSize_o   - gap height currently in force
// Modports: master = generator, slave = consumer/driver of step.
interface pipe_column_gen_if #(
  parameter int ROWS = 16
);
  localparam int P = $clog2(ROWS);

  logic            step_i;
  logic [ROWS-1:0] col_o;
  logic            colValid_o;
  logic            pipeStart_o;
  logic [P-1:0]    gapTop_o;
  logic [P:0]      gapSize_o;

  modport master (
    input  step_i,
    output col_o, colValid_o, pipeStart_o, gapTop_o, gapSize_o
  );

  modport slave (
    output step_i,
    input  col_o, colValid_o, pipeStart_o, gapTop_o, gapSize_o
  );
endinterface

// File: rtl/pipe_column_gen.sv
// pipe_column_gen
// Obstacle-column generator for the LED-matrix side-scroller. Each step emits
// one ROWS-bit column: PIPE_W wall columns with a random gap, then spacer
// columns, repeating every SPACING steps.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - pipe_column_gen_if.master (step in; column, pulses, gap info out)
// Optional feature: define PIPE_GEN_SHRINK_EN to shrink the gap by one row
// every 8th obstacle, down to MIN_GAP. Without it the gap is fixed at GAP.
module pipe_column_gen #(
  parameter int          ROWS    = 16,
  parameter int          GAP     = 4,
  parameter int          MIN_GAP = 2,
  parameter int          SPACING = 5,
  parameter int          PIPE_W  = 1,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input logic               clk,
  input logic               reset,
  pipe_column_gen_if.master bus
);

  localparam int P        = $clog2(ROWS);
  localparam int GW       = P + 1;
  localparam int PHW      = (SPACING > 1) ? $clog2(SPACING) : 1;
  // Never start below the shrink floor, even if misconfigured.
  localparam int GAP_INIT = (GAP < MIN_GAP) ? MIN_GAP : GAP;

  logic [ROWS-1:0] col_q, col_d;
  logic            colValid_q, colValid_d;
  logic            pipeStart_q, pipeStart_d;
  logic [P-1:0]    gapTop_q, gapTop_d;
  logic [PHW-1:0]  phase_q, phase_d;
  logic [7:0]      lfsr_q, lfsr_d;

  // gap: height used for the next draw; emitGap: height of the pipe being emitted
  logic [GW-1:0]   gap;
  logic [GW-1:0]   emitGap;

  logic [P-1:0]    drawR;
  logic [P-1:0]    drawPos;
  int              drawRange;

`ifdef PIPE_GEN_SHRINK_EN
  logic [GW-1:0]   gap_q, gap_d;
  logic [GW-1:0]   pipeGap_q, pipeGap_d;
  logic [2:0]      pipeCnt_q, pipeCnt_d;

  assign gap     = gap_q;
  // Latched at the draw so a shrink never reshapes a pipe mid-emission.
  assign emitGap = pipeGap_q;
`else
  assign gap     = GW'(GAP_INIT);
  assign emitGap = GW'(GAP_INIT);
`endif

  // Wall column with rows pos..pos+g-1 cleared.
  function automatic logic [ROWS-1:0] wallMask(input logic [P-1:0] pos, input logic [GW-1:0] g);
    logic [ROWS-1:0] m;
    m = '1;
    for (int i = 0; i < ROWS; i++) begin
      if ((i >= int'(pos)) && (i < int'(pos) + int'(g))) m[i] = 1'b0;
    end
    return m;
  endfunction

  // Gap position from the pre-shift LFSR; raw values beyond the legal range
  // fold back by subtracting the range instead of re-drawing.
  always_comb begin
    drawR     = lfsr_q[P-1:0];
    drawRange = ROWS - int'(gap) + 1;
    if (int'(drawR) >= drawRange) drawPos = P'(int'(drawR) - drawRange);
    else                          drawPos = drawR;
  end

  // Next-state logic: the LFSR always runs; everything else moves only on step.
  always_comb begin
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    phase_d     = phase_q;
    col_d       = col_q;
    gapTop_d    = gapTop_q;
    colValid_d  = 1'b0;
    pipeStart_d = 1'b0;
`ifdef PIPE_GEN_SHRINK_EN
    gap_d       = gap_q;
    pipeGap_d   = pipeGap_q;
    pipeCnt_d   = pipeCnt_q;
`endif
    if (bus.step_i) begin
      colValid_d = 1'b1;
      phase_d    = (phase_q == PHW'(SPACING - 1)) ? '0 : phase_q + 1'b1;
      if (phase_q == '0) begin
        gapTop_d    = drawPos;
        pipeStart_d = 1'b1;
        col_d       = wallMask(drawPos, gap);
`ifdef PIPE_GEN_SHRINK_EN
        pipeGap_d   = gap_q;
        pipeCnt_d   = pipeCnt_q + 3'd1;
        // Shrink lands after this draw, so it affects the next obstacle.
        if (pipeCnt_q == 3'd7) begin
          gap_d = (int'(gap_q) > MIN_GAP) ? gap_q - 1'b1 : GW'(MIN_GAP);
        end
`endif
      end else if (int'(phase_q) < PIPE_W) begin
        col_d = wallMask(gapTop_q, emitGap);
      end else begin
        col_d = '0;
      end
    end
  end

  // State registers; reset also aborts a partially emitted multi-column pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      colValid_q  <= 1'b0;
      pipeStart_q <= 1'b0;
      gapTop_q    <= '0;
      phase_q     <= '0;
      lfsr_q      <= SEED;
    end else begin
      col_q       <= col_d;
      colValid_q  <= colValid_d;
      pipeStart_q <= pipeStart_d;
      gapTop_q    <= gapTop_d;
      phase_q     <= phase_d;
      lfsr_q      <= lfsr_d;
    end
  end

`ifdef PIPE_GEN_SHRINK_EN
  // Difficulty-ramp registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q     <= GW'(GAP_INIT);
      pipeGap_q <= GW'(GAP_INIT);
      pipeCnt_q <= '0;
    end else begin
      gap_q     <= gap_d;
      pipeGap_q <= pipeGap_d;
      pipeCnt_q <= pipeCnt_d;
    end
  end
`endif

  assign bus.col_o       = col_q;
  assign bus.colValid_o  = colValid_q;
  assign bus.pipeStart_o = pipeStart_q;
  assign bus.gapTop_o    = gapTop_q;
  assign bus.gapSize_o   = gap;

endmodule

// File: tb/tb_pipe_column_gen.sv
// tb_pipe_column_gen
// Directed bench for pipe_column_gen. dutA uses the defaults (16 rows, gap 4,
// spacing 5, 1-wide pipes); dutB uses 2-wide pipes with spacing 4.
// Expected columns are hand-derived from the SEED=A5 LFSR sequence
// (A5 4A 95 2A 54 A9 53 A7 4E 9D 3B 77 EE DD BB 76 EC D9 B3 67 CF ...),
// plus a small reference model for a long run of random step patterns.
module tb_pipe_column_gen;

  localparam int ROWS = 16;

  logic clk = 1'b0;
  logic resetA;
  logic resetB;

  always #5 clk = ~clk;

  pipe_column_gen_if #(.ROWS(ROWS)) busA ();
  pipe_column_gen_if #(.ROWS(ROWS)) busB ();

  pipe_column_gen #(
    .ROWS(ROWS), .GAP(4), .MIN_GAP(2), .SPACING(5), .PIPE_W(1), .SEED(8'hA5)
  ) dutA (
    .clk(clk), .reset(resetA), .bus(busA)
  );

  pipe_column_gen #(
    .ROWS(ROWS), .GAP(4), .MIN_GAP(2), .SPACING(4), .PIPE_W(2), .SEED(8'hA5)
  ) dutB (
    .clk(clk), .reset(resetB), .bus(busB)
  );

  int compared   = 0;
  int mismatched = 0;

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives both DUTs for one clock, then waits 1 time unit past the edge.
  task automatic applyStimulus(input logic stepA, input logic rstA, input logic stepB, input logic rstB);
    busA.step_i = stepA;
    resetA      = rstA;
    busB.step_i = stepB;
    resetB      = rstB;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsrNext(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic int foldPos(input logic [7:0] l, input int g);
    int r;
    int range;
    r     = int'(l[3:0]);
    range = ROWS - g + 1;
    return (r >= range) ? r - range : r;
  endfunction

  function automatic logic [ROWS-1:0] maskOf(input int pos, input int g);
    logic [ROWS-1:0] m;
    m = '1;
    for (int i = pos; i < pos + g; i++) m[i] = 1'b0;
    return m;
  endfunction

  // Hand-computed expectations for dutA's 15 consecutive steps after reset.
  logic [15:0] wallTable [1:15];
  int          pulses;
  int          expGapAt8;
  int          expGapAt16;
  int          expGapAt24;

  // Model state for the long run.
  logic [7:0]      mLfsr;
  int              mPhase;
  int              mGap;
  int              mCnt;
  int              mTop;
  logic [ROWS-1:0] mCol;
  int              draws;
  int              cycles;
  int              drawGap;
  logic            stp;
  logic            expPs;

  initial begin
    for (int k = 1; k <= 15; k++) wallTable[k] = 16'h0000;
    wallTable[1]  = 16'hFE1F;
    wallTable[6]  = 16'hE1FF;
    wallTable[11] = 16'h87FF;
`ifdef PIPE_GEN_SHRINK_EN
    expGapAt8  = 3;
    expGapAt16 = 2;
    expGapAt24 = 2;
`else
    expGapAt8  = 4;
    expGapAt16 = 4;
    expGapAt24 = 4;
`endif

    busA.step_i = 1'b0;
    busB.step_i = 1'b0;
    resetA      = 1'b1;
    resetB      = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

    // Reset values.
    checkOutput("rstCol", 32'(busA.col_o), 32'h0);
    checkOutput("rstValid", 32'(busA.colValid_o), 32'h0);
    checkOutput("rstPipeStart", 32'(busA.pipeStart_o), 32'h0);
    checkOutput("rstGapTop", 32'(busA.gapTop_o), 32'h0);
    checkOutput("rstGapSize", 32'(busA.gapSize_o), 32'd4);
    checkOutput("rstColB", 32'(busB.col_o), 32'h0);

    // 20 idle cycles: nothing emitted while the LFSR runs on.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("idleCol", 32'(busA.col_o), 32'h0);
      checkOutput("idleValid", 32'(busA.colValid_o), 32'h0);
    end

    // LFSR is now CF: r = 15 folds to pos 2, rows 2..5 clear.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("foldCol", 32'(busA.col_o), 32'hFFC3);
    checkOutput("foldGapTop", 32'(busA.gapTop_o), 32'd2);
    checkOutput("foldPipeStart", 32'(busA.pipeStart_o), 32'd1);
    checkOutput("foldValid", 32'(busA.colValid_o), 32'd1);
    checkOutput("foldGapSize", 32'(busA.gapSize_o), 32'd4);

    // Without step the column holds and the pulses drop.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("holdCol", 32'(busA.col_o), 32'hFFC3);
      checkOutput("holdValid", 32'(busA.colValid_o), 32'h0);
      checkOutput("holdPipeStart", 32'(busA.pipeStart_o), 32'h0);
      checkOutput("holdGapTop", 32'(busA.gapTop_o), 32'd2);
    end

    // Reset, then 15 consecutive steps: walls at steps 1, 6, 11.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    pulses = 0;
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("runCol%0d", k), 32'(busA.col_o), 32'(wallTable[k]));
      checkOutput($sformatf("runValid%0d", k), 32'(busA.colValid_o), 32'd1);
      if (busA.pipeStart_o) pulses++;
      if (k == 1)  checkOutput("runGapTop1", 32'(busA.gapTop_o), 32'd5);
      if (k == 6)  checkOutput("runGapTop6", 32'(busA.gapTop_o), 32'd9);
      if (k == 11) checkOutput("runGapTop11", 32'(busA.gapTop_o), 32'd11);
    end
    checkOutput("runPulses", 32'(pulses), 32'd3);

    // dutB: two identical walls, two spacers, then a fresh pipe.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bWall1", 32'(busB.col_o), 32'hFE1F);
    checkOutput("bStart1", 32'(busB.pipeStart_o), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bWall2", 32'(busB.col_o), 32'hFE1F);
    checkOutput("bStart2", 32'(busB.pipeStart_o), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bSpace1", 32'(busB.col_o), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bSpace2", 32'(busB.col_o), 32'h0);
    checkOutput("bSpaceValid", 32'(busB.colValid_o), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bNextWall", 32'(busB.col_o), 32'hFF0F);
    checkOutput("bNextStart", 32'(busB.pipeStart_o), 32'd1);
    // Reset wins over step between the two wall columns.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("bAbortCol", 32'(busB.col_o), 32'h0);
    checkOutput("bAbortValid", 32'(busB.colValid_o), 32'h0);
    checkOutput("bAbortGapTop", 32'(busB.gapTop_o), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bFreshWall", 32'(busB.col_o), 32'hFE1F);
    checkOutput("bFreshStart", 32'(busB.pipeStart_o), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bFreshWall2", 32'(busB.col_o), 32'hFE1F);
    checkOutput("bFreshStart2", 32'(busB.pipeStart_o), 32'd0);

    // Long run of 1000 draws with random idle cycles against a reference model.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    mLfsr  = 8'hA5;
    mPhase = 0;
    mGap   = 4;
    mCnt   = 0;
    mTop   = 0;
    mCol   = '0;
    draws  = 0;
    cycles = 0;
    while (draws < 1000 && cycles < 20000) begin
      stp     = ($urandom_range(0, 3) != 0);
      expPs   = 1'b0;
      drawGap = 0;
      if (stp) begin
        if (mPhase == 0) begin
          mTop    = foldPos(mLfsr, mGap);
          mCol    = maskOf(mTop, mGap);
          expPs   = 1'b1;
          drawGap = mGap;
`ifdef PIPE_GEN_SHRINK_EN
          if (mCnt == 7) mGap = (mGap - 1 < 2) ? 2 : mGap - 1;
          mCnt = (mCnt + 1) % 8;
`endif
        end else begin
          mCol = '0;
        end
        mPhase = (mPhase + 1) % 5;
      end
      mLfsr = lfsrNext(mLfsr);
      applyStimulus(stp, 1'b0, 1'b0, 1'b1);
      cycles++;
      checkOutput("modelCol", 32'(busA.col_o), 32'(mCol));
      checkOutput("modelValid", 32'(busA.colValid_o), 32'(stp));
      checkOutput("modelPipeStart", 32'(busA.pipeStart_o), 32'(expPs));
      checkOutput("modelGapTop", 32'(busA.gapTop_o), 32'(mTop));
      checkOutput("modelGapSize", 32'(busA.gapSize_o), 32'(mGap));
      if (expPs) begin
        draws++;
        checkOutput("gapWithinColumn", 32'(int'(busA.gapTop_o) + drawGap <= ROWS), 32'd1);
        checkOutput("clearedRows", 32'(ROWS - $countones(busA.col_o)), 32'(drawGap));
        if (draws == 8)  checkOutput("gapAfter8", 32'(busA.gapSize_o), 32'(expGapAt8));
        if (draws == 16) checkOutput("gapAfter16", 32'(busA.gapSize_o), 32'(expGapAt16));
        if (draws == 24) checkOutput("gapAfter24", 32'(busA.gapSize_o), 32'(expGapAt24));
      end
    end
    if (draws < 1000) checkOutput("drawBudget", 32'(draws), 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
